frame_mem_arbiter: RTL and testbench
====================================

FRAME_MEM_ARBITER -- requirements
Module: frame_mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 22, memory word address width.
REQ-002 Parameter: BURST_LEN, 8, words per burst; power of two, 2..64.
REQ-003 Parameter: FRAME_WORDS, 307200, words per frame (640x480); multiple of BURST_LEN.
REQ-004 Parameter: WR_STARVE_MAX, 64, writer wait cycles before it overrides display priority.
REQ-005 Port: iCLK  in  1  sole clock; all logic on its rising edge.
REQ-006 Port: iRST_N  in  1  reset, asynchronous, active-low.
REQ-007 Port: iRd_Req  in  1  display line buffer below refill threshold; level.
REQ-008 Port: iRd_Frame_Start  in  1  one-cycle pulse at display vertical sync.
REQ-009 Port: iWr_Req  in  1  camera FIFO holds at least BURST_LEN words; level.
REQ-010 Port: iWr_Frame_Start  in  1  one-cycle pulse at camera frame start.
REQ-011 Port: oRd_Grant  out  1  one-cycle pulse on read-command acceptance.
REQ-012 Port: oWr_Grant  out  1  one-cycle pulse on write-command acceptance.
REQ-013 Port: oMem_Cmd_Valid  out  1  command valid toward memory controller.
REQ-014 Port: iMem_Cmd_Ready  in  1  memory accepts command when high with valid.
REQ-015 Port: oMem_Cmd_Write  out  1  1 = write burst, 0 = read burst.
REQ-016 Port: oMem_Addr  out  ADDR_W  burst start word address.
REQ-017 Port: iMem_Done  in  1  one-cycle pulse when accepted burst completes.
REQ-018 Port: oBusy  out  1  high in any state other than IDLE.

Function
REQ-019 FSM states SHALL be IDLE, RD_CMD, WR_CMD, WAIT; exactly one burst outstanding at a time.
REQ-020 In IDLE: iWr_Req with starve count = WR_STARVE_MAX -> WR_CMD; else iRd_Req -> RD_CMD; else iWr_Req -> WR_CMD; else stay.
REQ-021 Starve counter SHALL increment (saturating at WR_STARVE_MAX) each cycle iWr_Req is high and the FSM is not in WR_CMD, and clear on oWr_Grant.
REQ-022 In RD_CMD/WR_CMD: oMem_Cmd_Valid high; oMem_Cmd_Write, oMem_Addr held stable until iMem_Cmd_Ready.
REQ-023 The handshake cycle (valid and ready) SHALL pulse the matching grant and move to WAIT next cycle; request deassertion while in a CMD state SHALL NOT withdraw the command.
REQ-024 In WAIT: iMem_Done -> IDLE next cycle, advancing the owning address by BURST_LEN; iMem_Done outside WAIT is ignored.
REQ-025 Read and write addresses SHALL be independent counters; advance from FRAME_WORDS-BURST_LEN SHALL wrap to 0.
REQ-026 Frame-start pulse while its counter has no burst in flight SHALL zero that counter next cycle.
REQ-027 Frame-start pulse while its counter's burst is in CMD or WAIT SHALL set a pending flag; on iMem_Done the counter loads 0 instead of advancing and the flag clears.
REQ-028 Frame start coincident with iMem_Done of its own burst SHALL result in address 0.
REQ-029 Minimum IDLE-to-IDLE burst cycle is 3 clocks (CMD, WAIT, IDLE); back-to-back grants SHALL be at least 3 cycles apart.

Reset
REQ-030 On iRST_N low: state IDLE, both addresses 0, starve count 0, pending flags 0, all outputs 0 (oMem_Addr 0, oBusy 0), immediately and independent of iCLK.
REQ-031 Reset mid-burst SHALL abandon the burst without further grants; first post-reset command uses address 0.

Structure
REQ-032 Shared package SHALL hold the FSM state enumeration and default BURST_LEN/FRAME_WORDS constants.
REQ-033 One sub-module, frame_addr_gen (counter, wrap, pending frame-start), SHALL be instantiated twice.

Verification
REQ-034 iRd_Req held, ready always 1, done 2 cycles after grant -> read addresses 0,8,16,...; after 38400 bursts wraps to 0.
REQ-035 iRd_Req and iWr_Req both held -> reads only until starve count hits 64, then exactly one write at address 0, then reads resume.
REQ-036 iMem_Cmd_Ready low 10 cycles in RD_CMD -> valid held, oMem_Addr unchanged, single oRd_Grant on cycle ready rises.
REQ-037 iRd_Frame_Start during WAIT with read address 120 -> after iMem_Done next read command at address 0, not 128.
REQ-038 iRST_N low during WAIT of a write at 64 -> outputs 0 asynchronously; after release first write at address 0.

Source files
------------

// File: rtl/frame_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// frame_mem_arbiter_pkg
// Shared definitions for the frame buffer memory arbiter:
//   - default geometry constants (address width, burst length, frame size,
//     writer starvation limit)
//   - FSM state encoding used by the arbiter
//   - small helper to classify command-issuing states
// -----------------------------------------------------------------------------
package frame_mem_arbiter_pkg;

    localparam int DEF_ADDR_W        = 22;
    localparam int DEF_BURST_LEN     = 8;
    localparam int DEF_FRAME_WORDS   = 307200;  // 640 x 480 words
    localparam int DEF_WR_STARVE_MAX = 64;

    // Arbiter FSM state encoding
    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE   = 2'd0;
    localparam fsm_state_t ST_RD_CMD = 2'd1;
    localparam fsm_state_t ST_WR_CMD = 2'd2;
    localparam fsm_state_t ST_WAIT   = 2'd3;

    // True for the states that present a command to the memory controller
    function automatic logic is_cmd_state(input fsm_state_t st);
        return (st == ST_RD_CMD) || (st == ST_WR_CMD);
    endfunction

endpackage

// File: rtl/frame_addr_gen.sv
// -----------------------------------------------------------------------------
// frame_addr_gen
// Burst start-address counter for one frame stream (display read or camera
// write). Advances by BURST_LEN when its burst completes, wraps at the end of
// the frame, and handles frame-start pulses: zero immediately when no burst
// of this stream is in flight, otherwise remember the request and load zero
// when the in-flight burst completes.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   frame_start  in   one-cycle frame-start pulse for this stream
//   burst_active in   this stream owns the current command or wait phase
//   burst_done   in   this stream's burst completed this cycle
//   addr_next    out  counter value after the coming clock edge
// -----------------------------------------------------------------------------
module frame_addr_gen
    import frame_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int BURST_LEN   = DEF_BURST_LEN,
    parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              burst_active,
    input  logic              burst_done,
    output logic [ADDR_W-1:0] addr_next
);

    localparam logic [ADDR_W-1:0] STEP_C = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(FRAME_WORDS - BURST_LEN);
    localparam logic [ADDR_W-1:0] ZERO_C = {ADDR_W{1'b0}};

    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_next_s;
    logic              pending_r;
    logic              pending_next_s;

    // Next counter value and deferred frame-start flag
    always_comb begin
        addr_next_s    = addr_r;
        pending_next_s = pending_r;
        if (burst_done) begin
            // A frame start seen during this burst, or arriving with its
            // completion, restarts the frame instead of advancing.
            pending_next_s = 1'b0;
            if (pending_r || frame_start) begin
                addr_next_s = ZERO_C;
            end else if (addr_r >= LAST_C) begin
                addr_next_s = ZERO_C;
            end else begin
                addr_next_s = addr_r + STEP_C;
            end
        end else if (frame_start) begin
            if (burst_active) begin
                pending_next_s = 1'b1;
            end else begin
                addr_next_s = ZERO_C;
            end
        end else begin
            addr_next_s    = addr_r;
            pending_next_s = pending_r;
        end
    end

    // Counter and pending-flag state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r    <= ZERO_C;
            pending_r <= 1'b0;
        end else begin
            addr_r    <= addr_next_s;
            pending_r <= pending_next_s;
        end
    end

    assign addr_next = addr_next_s;

endmodule

// File: rtl/frame_mem_arbiter.sv
// -----------------------------------------------------------------------------
// frame_mem_arbiter
// Arbitrates a single memory controller between a display reader and a camera
// writer, one burst outstanding at a time. Display reads win in IDLE unless
// the writer has waited WR_STARVE_MAX cycles. Each stream keeps its own
// frame address counter (frame_addr_gen).
//
// Ports:
//   iCLK             in   clock, rising edge
//   iRST_N           in   asynchronous active-low reset
//   iRd_Req          in   display line buffer needs a refill (level)
//   iRd_Frame_Start  in   display vsync pulse
//   iWr_Req          in   camera FIFO holds a full burst (level)
//   iWr_Frame_Start  in   camera frame-start pulse
//   oRd_Grant        out  pulse when a read command is accepted
//   oWr_Grant        out  pulse when a write command is accepted
//   oMem_Cmd_Valid   out  command valid toward memory controller
//   iMem_Cmd_Ready   in   memory controller accepts command
//   oMem_Cmd_Write   out  1 = write burst, 0 = read burst
//   oMem_Addr        out  burst start word address
//   iMem_Done        in   pulse when the accepted burst completes
//   oBusy            out  high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module frame_mem_arbiter
    import frame_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int BURST_LEN     = DEF_BURST_LEN,
    parameter int FRAME_WORDS   = DEF_FRAME_WORDS,
    parameter int WR_STARVE_MAX = DEF_WR_STARVE_MAX
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iRd_Req,
    input  logic              iRd_Frame_Start,
    input  logic              iWr_Req,
    input  logic              iWr_Frame_Start,
    output logic              oRd_Grant,
    output logic              oWr_Grant,
    output logic              oMem_Cmd_Valid,
    input  logic              iMem_Cmd_Ready,
    output logic              oMem_Cmd_Write,
    output logic [ADDR_W-1:0] oMem_Addr,
    input  logic              iMem_Done,
    output logic              oBusy
);

    localparam int STARVE_W = $clog2(WR_STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX_C  = STARVE_W'(WR_STARVE_MAX);
    localparam logic [STARVE_W-1:0] STARVE_ONE_C  = STARVE_W'(1);
    localparam logic [STARVE_W-1:0] STARVE_ZERO_C = {STARVE_W{1'b0}};
    localparam logic [ADDR_W-1:0]   ADDR_ZERO_C   = {ADDR_W{1'b0}};

    fsm_state_t          state_r;
    fsm_state_t          state_next_s;
    logic                owner_wr_r;
    logic                owner_wr_next_s;
    logic [STARVE_W-1:0] starve_r;
    logic [STARVE_W-1:0] starve_next_s;
    logic                cmd_valid_r;
    logic                cmd_write_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [ADDR_W-1:0]   cmd_addr_next_s;
    logic                busy_r;

    logic                rd_grant_s;
    logic                wr_grant_s;
    logic                done_s;
    logic                rd_active_s;
    logic                wr_active_s;
    logic                rd_done_s;
    logic                wr_done_s;
    logic [ADDR_W-1:0]   rd_addr_next_s;
    logic [ADDR_W-1:0]   wr_addr_next_s;

    // Grants are the handshake itself, so they cannot lag the accept cycle;
    // they are qualified by the registered state and therefore 0 in reset.
    assign rd_grant_s = (state_r == ST_RD_CMD) & iMem_Cmd_Ready;
    assign wr_grant_s = (state_r == ST_WR_CMD) & iMem_Cmd_Ready;

    // Completion only counts while a burst is actually outstanding
    assign done_s    = (state_r == ST_WAIT) & iMem_Done;
    assign rd_done_s = done_s & ~owner_wr_r;
    assign wr_done_s = done_s &  owner_wr_r;

    assign rd_active_s = (state_r == ST_RD_CMD) | ((state_r == ST_WAIT) & ~owner_wr_r);
    assign wr_active_s = (state_r == ST_WR_CMD) | ((state_r == ST_WAIT) &  owner_wr_r);

    frame_addr_gen #(
        .ADDR_W      (ADDR_W),
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS)
    ) u_rd_addr (
        .clk          (iCLK),
        .rst_n        (iRST_N),
        .frame_start  (iRd_Frame_Start),
        .burst_active (rd_active_s),
        .burst_done   (rd_done_s),
        .addr_next    (rd_addr_next_s)
    );

    frame_addr_gen #(
        .ADDR_W      (ADDR_W),
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS)
    ) u_wr_addr (
        .clk          (iCLK),
        .rst_n        (iRST_N),
        .frame_start  (iWr_Frame_Start),
        .burst_active (wr_active_s),
        .burst_done   (wr_done_s),
        .addr_next    (wr_addr_next_s)
    );

    // FSM next-state: starved writer first, then display, then writer
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (iWr_Req && (starve_r == STARVE_MAX_C)) begin
                    state_next_s = ST_WR_CMD;
                end else if (iRd_Req) begin
                    state_next_s = ST_RD_CMD;
                end else if (iWr_Req) begin
                    state_next_s = ST_WR_CMD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RD_CMD, ST_WR_CMD: begin
                // Once issued, a command stays until accepted regardless of
                // the requester dropping its request.
                if (iMem_Cmd_Ready) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_WAIT: begin
                if (iMem_Done) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Burst ownership, latched when a command phase begins
    always_comb begin
        owner_wr_next_s = owner_wr_r;
        if (state_next_s == ST_WR_CMD) begin
            owner_wr_next_s = 1'b1;
        end else if (state_next_s == ST_RD_CMD) begin
            owner_wr_next_s = 1'b0;
        end else begin
            owner_wr_next_s = owner_wr_r;
        end
    end

    // Writer starvation counter: counts waiting cycles, saturates, clears on grant
    always_comb begin
        starve_next_s = starve_r;
        if (wr_grant_s) begin
            starve_next_s = STARVE_ZERO_C;
        end else if (iWr_Req && (state_r != ST_WR_CMD) && (starve_r != STARVE_MAX_C)) begin
            starve_next_s = starve_r + STARVE_ONE_C;
        end else begin
            starve_next_s = starve_r;
        end
    end

    // Address presented in the next cycle; counters are stable during a
    // command phase, so taking the post-edge value also picks up a frame
    // restart that lands on the IDLE cycle that launches the command.
    always_comb begin
        cmd_addr_next_s = ADDR_ZERO_C;
        case (state_next_s)
            ST_RD_CMD: cmd_addr_next_s = rd_addr_next_s;
            ST_WR_CMD: cmd_addr_next_s = wr_addr_next_s;
            default:   cmd_addr_next_s = ADDR_ZERO_C;
        endcase
    end

    // FSM state, arbitration bookkeeping and registered command outputs
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_r     <= ST_IDLE;
            owner_wr_r  <= 1'b0;
            starve_r    <= STARVE_ZERO_C;
            cmd_valid_r <= 1'b0;
            cmd_write_r <= 1'b0;
            mem_addr_r  <= ADDR_ZERO_C;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            owner_wr_r  <= owner_wr_next_s;
            starve_r    <= starve_next_s;
            cmd_valid_r <= is_cmd_state(state_next_s);
            cmd_write_r <= (state_next_s == ST_WR_CMD);
            mem_addr_r  <= cmd_addr_next_s;
            busy_r      <= (state_next_s != ST_IDLE);
        end
    end

    assign oRd_Grant      = rd_grant_s;
    assign oWr_Grant      = wr_grant_s;
    assign oMem_Cmd_Valid = cmd_valid_r;
    assign oMem_Cmd_Write = cmd_write_r;
    assign oMem_Addr      = mem_addr_r;
    assign oBusy          = busy_r;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_frame_mem_arbiter
// Directed bench for frame_mem_arbiter. Expected grants (kind + address) are
// queued as stimulus is applied; a memory responder pops and compares them on
// every grant and returns iMem_Done two cycles after each grant. A reduced
// frame size (256 words) keeps the wrap test short.
// -----------------------------------------------------------------------------
module tb_frame_mem_arbiter;

    localparam int AW  = 22;
    localparam int BL  = 8;
    localparam int FW  = 256;
    localparam int WSM = 64;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_req = 1'b0;
    logic          rd_frame = 1'b0;
    logic          wr_req = 1'b0;
    logic          wr_frame = 1'b0;
    logic          mem_ready = 1'b1;
    logic          mem_done = 1'b0;
    logic          rd_grant;
    logic          wr_grant;
    logic          cmd_valid;
    logic          cmd_write;
    logic [AW-1:0] mem_addr;
    logic          busy;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_rd = 0;
    int   exp_wr = 0;
    int   cyc = 0;
    int   last_g = -100;
    int   pend = 0;
    int   n_rd_grants = 0;

    frame_mem_arbiter #(
        .ADDR_W        (AW),
        .BURST_LEN     (BL),
        .FRAME_WORDS   (FW),
        .WR_STARVE_MAX (WSM)
    ) dut (
        .iCLK            (clk),
        .iRST_N          (rst_n),
        .iRd_Req         (rd_req),
        .iRd_Frame_Start (rd_frame),
        .iWr_Req         (wr_req),
        .iWr_Frame_Start (wr_frame),
        .oRd_Grant       (rd_grant),
        .oWr_Grant       (wr_grant),
        .oMem_Cmd_Valid  (cmd_valid),
        .iMem_Cmd_Ready  (mem_ready),
        .oMem_Cmd_Write  (cmd_write),
        .oMem_Addr       (mem_addr),
        .iMem_Done       (mem_done),
        .oBusy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push_rd();
        exp_t e;
        e.wr   = 1'b0;
        e.addr = AW'(exp_rd);
        q.push_back(e);
        exp_rd = (exp_rd + BL) % FW;
    endtask

    task automatic push_wr();
        exp_t e;
        e.wr   = 1'b1;
        e.addr = AW'(exp_wr);
        q.push_back(e);
        exp_wr = (exp_wr + BL) % FW;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_q(input int budget);
        int k = 0;
        while (q.size() != 0 && k < budget) begin
            step(1);
            k++;
        end
        check("queue_drained", 32'(q.size()), 32'd0);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            step(1);
            k++;
        end
        check("returns_idle", 32'(busy), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_grant"}, 32'(rd_grant), 32'd0);
        check({tag, "_wr_grant"}, 32'(wr_grant), 32'd0);
        check({tag, "_valid"},    32'(cmd_valid), 32'd0);
        check({tag, "_write"},    32'(cmd_write), 32'd0);
        check({tag, "_addr"},     32'(mem_addr), 32'd0);
        check({tag, "_busy"},     32'(busy), 32'd0);
    endtask

    // Memory responder: compares each grant against the scoreboard and
    // returns a done pulse two cycles after the grant.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            pend     = 0;
            mem_done = 1'b0;
        end else begin
            mem_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) mem_done = 1'b1;
            end
            if (rd_grant || wr_grant) begin
                check("grant_spacing", 32'((cyc - last_g) >= 3), 32'd1);
                last_g = cyc;
                check("single_grant", 32'(rd_grant & wr_grant), 32'd0);
                if (rd_grant) n_rd_grants++;
                if (q.size() == 0) begin
                    check("unexpected_grant", 32'(q.size()), 32'd1);
                end else begin
                    e = q.pop_front();
                    check("grant_kind", 32'({wr_grant, cmd_write}), 32'({e.wr, e.wr}));
                    check("grant_addr", 32'(mem_addr), 32'(e.addr));
                end
                pend = 2;
            end
        end
    end

    initial begin
        int a;
        int g0;
        int k;

        // Reset state
        step(3);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Continuous reads: 0,8,...,248 then wrap to 0,8
        rd_req = 1'b1;
        for (int i = 0; i < 34; i++) push_rd();
        wait_q(34 * 4 + 20);
        rd_req = 1'b0;
        wait_idle(10);

        // Memory stall: command held stable, request withdrawn, one grant
        mem_ready = 1'b0;
        rd_req    = 1'b1;
        a         = exp_rd;
        g0        = n_rd_grants;
        push_rd();
        k = 0;
        while (cmd_valid !== 1'b1 && k < 10) begin
            step(1);
            k++;
        end
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", 32'(cmd_valid), 32'd1);
            check("stall_write", 32'(cmd_write), 32'd0);
            check("stall_addr", 32'(mem_addr), 32'(a));
            check("stall_no_grant", 32'(rd_grant), 32'd0);
            rd_req = 1'b0;
            step(1);
        end
        check("stall_pending", 32'(q.size()), 32'd1);
        mem_ready = 1'b1;
        wait_q(10);
        wait_idle(10);
        check("stall_one_grant", 32'(n_rd_grants - g0), 32'd1);

        // Display vsync during WAIT of the burst at 120 restarts at 0
        rd_req = 1'b1;
        while (exp_rd != 120) push_rd();
        push_rd();
        wait_q(200);
        rd_frame = 1'b1;
        exp_rd   = 0;
        push_rd();
        push_rd();
        step(1);
        rd_frame = 1'b0;
        wait_q(20);
        // Vsync coincident with done of the burst at 8
        step(1);
        rd_frame = 1'b1;
        exp_rd   = 0;
        push_rd();
        step(1);
        rd_frame = 1'b0;
        wait_q(20);
        rd_req = 1'b0;
        wait_idle(10);

        // Both requesting: 16 reads until writer starves, one write, reads resume
        rd_req = 1'b1;
        wr_req = 1'b1;
        for (int i = 0; i < 16; i++) push_rd();
        push_wr();
        for (int i = 0; i < 4; i++) push_rd();
        wait_q(200);
        rd_req = 1'b0;
        wr_req = 1'b0;
        wait_idle(10);

        // Camera frame start while idle zeroes the write counter
        wr_frame = 1'b1;
        step(1);
        wr_frame = 1'b0;
        check("frame_start_idle_busy", 32'(busy), 32'd0);
        exp_wr = 0;
        wr_req = 1'b1;
        push_wr();
        wait_q(20);
        wr_req = 1'b0;
        wait_idle(10);

        // Reset during WAIT of the write at 64
        wr_req = 1'b1;
        while (exp_wr != 64) push_wr();
        push_wr();
        wait_q(100);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        step(3);
        check_outputs_zero("held_reset");
        exp_rd = 0;
        exp_wr = 0;
        push_wr();
        rst_n = 1'b1;
        wait_q(20);
        wr_req = 1'b0;
        wait_idle(10);
        rd_req = 1'b1;
        push_rd();
        wait_q(20);
        rd_req = 1'b0;
        wait_idle(10);

        step(5);
        check("final_queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
